// File: rtl/rns_to_int_mrc.sv
// Sequential RNS-to-integer decoder using mixed-radix conversion.
// Three elimination passes produce the mixed-radix digits, then three Horner steps rebuild the integer.
module rns_to_int_mrc #(
  parameter int M1 = 233,
  parameter int M2 = 239,
  parameter int M3 = 241,
  parameter int M4 = 251
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_rns,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        out_err
);

  function automatic int gcd(input int a, input int b);
    int x;
    int z;
    int t;
    x = a;
    z = b;
    while (z != 32'sd0) begin
      t = x % z;
      x = z;
      z = t;
    end
    return x;
  endfunction

  function automatic int mod_inv(input int a, input int m);
    int r;
    r = 32'sd0;
    for (int x = 32'sd1; x < m; x++) begin
      if ((((a * x) % m) == 32'sd1) && (r == 32'sd0)) begin
        r = x;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic bit params_ok();
    bit    ok;
    longint prod;
    ok = 1'b1;
    if (M1 < 32'sd2 || M1 > 32'sd255 || M2 < 32'sd2 || M2 > 32'sd255 ||
        M3 < 32'sd2 || M3 > 32'sd255 || M4 < 32'sd2 || M4 > 32'sd255) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    if (gcd(M1, M2) != 32'sd1 || gcd(M1, M3) != 32'sd1 || gcd(M1, M4) != 32'sd1 ||
        gcd(M2, M3) != 32'sd1 || gcd(M2, M4) != 32'sd1 || gcd(M3, M4) != 32'sd1) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    prod = longint'(M1) * longint'(M2) * longint'(M3) * longint'(M4);
    if (prod >= 64'sh1_0000_0000) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

  if (!params_ok()) begin : g_bad_params
    $error("rns_to_int_mrc: moduli must be 2..255, pairwise coprime, product below 2^32");
  end

  localparam logic [8:0]  M1_L  = 9'(M1);
  localparam logic [8:0]  M2_L  = 9'(M2);
  localparam logic [8:0]  M3_L  = 9'(M3);
  localparam logic [8:0]  M4_L  = 9'(M4);
  localparam logic [39:0] M1_W  = 40'(M1);
  localparam logic [39:0] M2_W  = 40'(M2);
  localparam logic [39:0] M3_W  = 40'(M3);
  localparam logic [8:0]  INV12 = 9'(mod_inv(M1 % M2, M2));
  localparam logic [8:0]  INV13 = 9'(mod_inv(M1 % M3, M3));
  localparam logic [8:0]  INV14 = 9'(mod_inv(M1 % M4, M4));
  localparam logic [8:0]  INV23 = 9'(mod_inv(M2 % M3, M3));
  localparam logic [8:0]  INV24 = 9'(mod_inv(M2 % M4, M4));
  localparam logic [8:0]  INV34 = 9'(mod_inv(M3 % M4, M4));

  // One elimination step: ((rj - (ak mod mj)) mod mj) * inv mod mj, with wrapping subtraction.
  function automatic logic [7:0] elim_step(input logic [7:0] rj, input logic [7:0] ak,
                                           input logic [8:0] mj, input logic [8:0] inv);
    logic [8:0]  ak_red;
    logic [8:0]  diff;
    logic [17:0] prod;
    ak_red = {1'b0, ak} % mj;
    if ({1'b0, rj} >= ak_red) begin
      diff = {1'b0, rj} - ak_red;
    end else begin
      diff = {1'b0, rj} + mj - ak_red;
    end
    prod = {9'd0, diff} * {9'd0, inv};
    return 8'(prod % {9'd0, mj});
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ELIM1 = 3'd1,
    ELIM2 = 3'd2,
    ELIM3 = 3'd3,
    HOR1  = 3'd4,
    HOR2  = 3'd5,
    HOR3  = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t      state_r;
  logic [7:0]  r1_r;
  logic [7:0]  r2_r;
  logic [7:0]  r3_r;
  logic [7:0]  r4_r;
  logic [39:0] acc_r;
  logic        err_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [31:0] y_r;
  logic        out_err_r;
  logic        in_err_s;

  assign in_err_s = ({1'b0, x_rns[7:0]}   >= M1_L) |
                    ({1'b0, x_rns[15:8]}  >= M2_L) |
                    ({1'b0, x_rns[23:16]} >= M3_L) |
                    ({1'b0, x_rns[31:24]} >= M4_L);

  // Conversion FSM; after ELIMk the register rk holds digit ak, so the Horner steps reuse r1..r4.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      r1_r        <= 8'd0;
      r2_r        <= 8'd0;
      r3_r        <= 8'd0;
      r4_r        <= 8'd0;
      acc_r       <= 40'd0;
      err_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      y_r         <= 32'd0;
      out_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            r1_r       <= x_rns[7:0];
            r2_r       <= x_rns[15:8];
            r3_r       <= x_rns[23:16];
            r4_r       <= x_rns[31:24];
            err_r      <= in_err_s;
            in_ready_r <= 1'b0;
            state_r    <= ELIM1;
          end else begin
            state_r    <= IDLE;
          end
        end
        ELIM1: begin
          r2_r    <= elim_step(r2_r, r1_r, M2_L, INV12);
          r3_r    <= elim_step(r3_r, r1_r, M3_L, INV13);
          r4_r    <= elim_step(r4_r, r1_r, M4_L, INV14);
          state_r <= ELIM2;
        end
        ELIM2: begin
          r3_r    <= elim_step(r3_r, r2_r, M3_L, INV23);
          r4_r    <= elim_step(r4_r, r2_r, M4_L, INV24);
          state_r <= ELIM3;
        end
        ELIM3: begin
          r4_r    <= elim_step(r4_r, r3_r, M4_L, INV34);
          state_r <= HOR1;
        end
        HOR1: begin
          acc_r   <= {32'd0, r4_r} * M3_W + {32'd0, r3_r};
          state_r <= HOR2;
        end
        HOR2: begin
          acc_r   <= acc_r * M2_W + {32'd0, r2_r};
          state_r <= HOR3;
        end
        HOR3: begin
          y_r         <= err_r ? 32'd0 : 32'(acc_r * M1_W + {32'd0, r1_r});
          out_err_r   <= err_r;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign y         = y_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_rns_to_int_mrc.sv
// Scoreboard bench for rns_to_int_mrc: the driver queues expected results at acceptance,
// a negedge monitor checks value, latency and hold stability of every presented result.
module tb_rns_to_int_mrc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_rns;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        out_err;

  typedef struct {
    logic [31:0] y;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_rise = 0;
  int   prev_rise = 0;
  bit   seen = 1'b0;

  rns_to_int_mrc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_rns     (x_rns),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] ey, input logic ee);
    int t;
    bit ok;
    t  = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    x_rns    = w;
    while (!ok && t < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else t++;
    end
    if (ok) begin
      sb.push_back('{ey, ee, cyc});
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: word %h never accepted", w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_rns    = 32'hDEAD_BEEF;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compare every presented result against the queue head, latency on first sight.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: y=%0d err=%0b with nothing pending", y, out_err);
        end else begin
          e = sb[0];
          n_cmp++;
          if (y !== e.y || out_err !== e.err) begin
            n_bad++;
            $display("FAIL result: got y=%0d err=%0b, expected y=%0d err=%0b", y, out_err, e.y, e.err);
          end
          if (!seen) begin
            n_cmp++;
            if (cyc - e.acc_cyc != 7) begin
              n_bad++;
              $display("FAIL latency: got %0d cycles, expected 7", cyc - e.acc_cyc);
            end
            prev_rise = last_rise;
            last_rise = cyc;
            seen      = 1'b1;
          end
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int t;
    reset     = 1'b1;
    in_valid  = 1'b0;
    x_rns     = 32'h0000_0000;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_y", y, 32'd0);
    chk("reset_out_err", 32'(out_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic decodes, including M1 itself and the all-maximum word M-1.
    send(32'h0000_0000, 32'd0, 1'b0);
    drain();
    send(32'hF724_2C44, 32'd1000, 1'b0);
    send(32'h0101_0101, 32'd1, 1'b0);
    send(32'h2E36_9CE5, 32'd12345, 1'b0);
    send(32'hE9E9_E900, 32'd233, 1'b0);
    send(32'hFAF0_EEE8, 32'd3368562316, 1'b0);
    drain();

    // Out-of-range residues in different lanes, then a clean word.
    send(32'h0000_00E9, 32'd0, 1'b1);
    send(32'hF724_2C44, 32'd1000, 1'b0);
    send(32'hFB00_0000, 32'd0, 1'b1);
    send(32'hFFFF_FFFF, 32'd0, 1'b1);
    send(32'h0101_0101, 32'd1, 1'b0);
    drain();

    // Backpressure: hold DONE for 5 cycles, pulse in_valid, then release.
    out_ready = 1'b0;
    send(32'h2E36_9CE5, 32'd12345, 1'b0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid_high", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      in_valid = (i == 1);
      x_rns    = 32'h0101_0101;
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    drain();

    // Reset during ELIM2 aborts the conversion.
    send(32'hFAF0_EEE8, 32'd3368562316, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_no_output", 32'(out_valid), 32'd0);

    // Normal decode after the abort, then back-to-back results 8 cycles apart.
    send(32'hF724_2C44, 32'd1000, 1'b0);
    send(32'h2E36_9CE5, 32'd12345, 1'b0);
    drain();
    chk("back_to_back_spacing", 32'(last_rise - prev_rise), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
